uart_tx_serializer: RTL and testbench

- UART transmitter: accepts one parallel byte via a valid/busy handshake and serialises it as a standard frame on TX_OUT.
- Frame order: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Runs on the same oversampling clock as the receive path; each bit is held for PRESCALE clocks, so TX and RX share one clock domain and one baud setting.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_bit_timer.sv | 49 ++++
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity constants, default
// sizing and frame-length constants used by the transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned DEFAULT_PRESCALE   = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Bit periods per frame with a single stop bit.
  localparam int unsigned FRAME_BITS_NO_PARITY = 10;
  localparam int unsigned FRAME_BITS_PARITY    = 11;

  // Bit periods in a single-stop-bit frame for a given parity setting.
  function automatic int unsigned frame_bits(input logic parity_en);
    return parity_en ? FRAME_BITS_PARITY : FRAME_BITS_NO_PARITY;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: an edge counter that divides each bit
// into PRESCALE clocks, and a bit counter that tracks data bits in DATA.
// Produces bit_done (end of the current bit period) and last_data_bit
// (end of the final data bit) strobes for the FSM.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE   = DEFAULT_PRESCALE,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic in_data,
  output logic bit_done,
  output logic last_data_bit
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;

  assign bit_done      = active && (edge_cnt == CW'(PRESCALE - 1));
  assign last_data_bit = in_data && bit_done && (bit_cnt == 4'(DATA_WIDTH - 1));

  // Edge counter: runs 0..PRESCALE-1 while a frame is active, held at 0 in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!active || bit_done) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Bit counter: advances once per data bit, cleared outside DATA and on its last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (!in_data || last_data_bit) begin
      bit_cnt <= '0;
    end else if (bit_done) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a parallel byte on Data_Valid while idle and
// sends start bit, data LSB first, optional parity, and stop bit on TX_OUT.
// Each bit lasts PRESCALE clocks. Define UART_TX_TWO_STOP_EN to send two
// stop bits instead of one.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned PRESCALE   = DEFAULT_PRESCALE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_reg;
  logic                  par_type_reg;
  logic                  parity_calc;
  logic                  bit_done;
  logic                  last_data_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_second;
`endif

  // Parity always comes from the latched byte so mid-frame input changes are harmless.
  always_comb begin
    parity_calc = ^data_reg;
    if (par_type_reg == PARITY_ODD) begin
      parity_calc = ~(^data_reg);
    end
  end

  uart_tx_bit_timer #(
    .PRESCALE   (PRESCALE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_timer (
    .clk           (CLK),
    .rst_n         (RST),
    .active        (state != TX_IDLE),
    .in_data       (state == TX_DATA),
    .bit_done      (bit_done),
    .last_data_bit (last_data_bit)
  );

  // Frame FSM; TX_OUT is loaded with the next bit's level on the edge that enters it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= TX_IDLE;
      TX_OUT       <= 1'b1;
      Busy         <= 1'b0;
      data_reg     <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= PARITY_EVEN;
`ifdef UART_TX_TWO_STOP_EN
      stop_second  <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            data_reg     <= P_Data;
            shift_reg    <= P_Data;
            par_en_reg   <= Parity_Enable;
            par_type_reg <= Parity_Type;
            state        <= TX_START;
            TX_OUT       <= 1'b0;
            Busy         <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_done) begin
            state     <= TX_DATA;
            TX_OUT    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        TX_DATA: begin
          if (last_data_bit) begin
            if (par_en_reg) begin
              state  <= TX_PARITY;
              TX_OUT <= parity_calc;
            end else begin
              state  <= TX_STOP;
              TX_OUT <= 1'b1;
            end
          end else if (bit_done) begin
            TX_OUT    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        TX_PARITY: begin
          if (bit_done) begin
            state  <= TX_STOP;
            TX_OUT <= 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
            // First stop-bit period just arms the second; line stays high throughout.
            if (!stop_second) begin
              stop_second <= 1'b1;
            end else begin
              stop_second <= 1'b0;
              state       <= TX_IDLE;
              Busy        <= 1'b0;
            end
`else
            state <= TX_IDLE;
            Busy  <= 1'b0;
`endif
          end
        end
        default: begin
          state  <= TX_IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (PRESCALE=8, 8 data bits).
module tb_uart_tx_serializer;

  localparam int P = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int XS = (NSTOP - 1) * P;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Data_Valid;
  logic [7:0] P_Data;
  logic       Parity_Enable;
  logic       Parity_Type;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_serializer #(
    .DATA_WIDTH (8),
    .PRESCALE   (P)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Data_Valid    (Data_Valid),
    .P_Data        (P_Data),
    .Parity_Enable (Parity_Enable),
    .Parity_Type   (Parity_Type),
    .TX_OUT        (TX_OUT),
    .Busy          (Busy)
  );

  task automatic chk(input logic observed, input logic expected, input string tag);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Requests one frame at the current negedge and checks every bit slot, the
  // Busy length and the first idle cycle. Optionally disturbs inputs at poke_cyc.
  task automatic frame(input logic [7:0] data, input logic par_en, input logic par_type,
                       input logic exp_par, input int exp_busy, input int poke_cyc,
                       input logic [7:0] poke_data, input logic poke_ptype,
                       input logic keep_valid, input string tag);
    logic [11:0] exp_bits;
    logic        slot_bad;
    logic        seen;
    int          nslots;
    int          busy_cnt;
    int          c;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = data[i];
    if (par_en) exp_bits[9] = exp_par;
    nslots = 9 + (par_en ? 1 : 0) + NSTOP;
    Data_Valid    = 1'b1;
    P_Data        = data;
    Parity_Enable = par_en;
    Parity_Type   = par_type;
    @(posedge CLK);
    @(negedge CLK);
    if (!keep_valid) Data_Valid = 1'b0;
    busy_cnt = 0;
    for (int s = 0; s < nslots; s++) begin
      slot_bad = 1'b0;
      seen     = exp_bits[s];
      for (int k = 0; k < P; k++) begin
        c = s * P + k;
        if (c == poke_cyc) begin
          P_Data      = poke_data;
          Parity_Type = poke_ptype;
          Data_Valid  = 1'b1;
        end else if (c == poke_cyc + 1 && !keep_valid) begin
          Data_Valid = 1'b0;
        end
        if (Busy === 1'b1) busy_cnt++;
        if (TX_OUT !== exp_bits[s] && !slot_bad) begin
          slot_bad = 1'b1;
          seen     = TX_OUT;
        end
        @(negedge CLK);
      end
      checks++;
      assert (seen === exp_bits[s]) else begin
        errors++;
        $error("FAIL %s slot %0d: observed %b expected %b", tag, s, seen, exp_bits[s]);
      end
    end
    checks++;
    assert (busy_cnt === exp_busy) else begin
      errors++;
      $error("FAIL %s busy_len: observed %0d expected %0d", tag, busy_cnt, exp_busy);
    end
    chk(Busy, 1'b0, {tag, " idle_busy"});
    chk(TX_OUT, 1'b1, {tag, " idle_tx"});
  endtask

  initial begin
    int quiet_bad;
    RST           = 1'b0;
    Data_Valid    = 1'b0;
    P_Data        = 8'h00;
    Parity_Enable = 1'b0;
    Parity_Type   = 1'b0;
    #12;
    chk(TX_OUT, 1'b1, "reset_tx");
    chk(Busy, 1'b0, "reset_busy");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Basic frame and parity variants.
    frame(8'hA5, 1'b0, 1'b0, 1'b0, 80 + XS, -1, 8'h00, 1'b0, 1'b0, "a5_nopar");
    frame(8'hA5, 1'b1, 1'b0, 1'b0, 88 + XS, -1, 8'h00, 1'b0, 1'b0, "a5_even");
    frame(8'hA5, 1'b1, 1'b1, 1'b1, 88 + XS, -1, 8'h00, 1'b0, 1'b0, "a5_odd");
    frame(8'h00, 1'b1, 1'b1, 1'b1, 88 + XS, -1, 8'h00, 1'b0, 1'b0, "00_odd");
    frame(8'hFF, 1'b1, 1'b0, 1'b0, 88 + XS, -1, 8'h00, 1'b0, 1'b0, "ff_even");

    // Data_Valid held high: back-to-back frames with one idle cycle between.
    frame(8'h3C, 1'b0, 1'b0, 1'b0, 80 + XS, 40, 8'hC3, 1'b0, 1'b1, "cont_3c");
    frame(8'hC3, 1'b0, 1'b0, 1'b0, 80 + XS, -1, 8'h00, 1'b0, 1'b0, "cont_c3");

    // Mid-frame request and input changes are ignored.
    frame(8'h55, 1'b1, 1'b0, 1'b0, 88 + XS, 20, 8'h11, 1'b1, 1'b0, "mid_55");
    quiet_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) quiet_bad++;
      @(negedge CLK);
    end
    checks++;
    assert (quiet_bad === 0) else begin
      errors++;
      $error("FAIL dropped_req: observed %0d active cycles expected 0", quiet_bad);
    end

    // Asynchronous reset in the middle of a frame.
    Data_Valid    = 1'b1;
    P_Data        = 8'h00;
    Parity_Enable = 1'b0;
    Parity_Type   = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (29) @(negedge CLK);
    chk(TX_OUT, 1'b0, "pre_rst_tx");
    chk(Busy, 1'b1, "pre_rst_busy");
    #2 RST = 1'b0;
    #1;
    chk(TX_OUT, 1'b1, "async_rst_tx");
    chk(Busy, 1'b0, "async_rst_busy");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk(TX_OUT, 1'b1, "post_rst_tx");
    chk(Busy, 1'b0, "post_rst_busy");
    frame(8'h81, 1'b1, 1'b1, 1'b1, 88 + XS, -1, 8'h00, 1'b0, 1'b0, "post_rst_81");

`ifdef UART_TX_TWO_STOP_EN
    frame(8'hF0, 1'b0, 1'b0, 1'b0, 88, -1, 8'h00, 1'b0, 1'b0, "f0_two_stop");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
